// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Brief    : Shared constants and types for the 10-LED bar pattern path
//             (pattern generator and trail/PWM stage).
//  Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int N_LEDS    = 10;
  localparam int LEVEL_W   = 3;
  localparam int LEVEL_MAX = (1 << LEVEL_W) - 1;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [N_LEDS-1:0]  led_vec_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/pwm_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_slot_timer
//  Brief    : PWM frame timebase. A prescaler divides CLK into slots; LEVEL_MAX
//             slots make one frame. Flags the frame-ending edge (combinational)
//             and pulses frame_start in the first cycle of every frame.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_slot_timer
  import led_pkg::*;
#(
  parameter int PWM_DIV = 4
) (
  input  logic   CLK,
  input  logic   RST,
  output level_t slot,
  output logic   frame_edge,
  output logic   frame_start
);

  // A one-cycle slot still needs a 1-bit prescaler register
  localparam int                c_pre_w     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PWM_DIV - 1);
  localparam level_t            c_slot_last = level_t'(LEVEL_MAX - 1);

  logic [c_pre_w-1:0] r_pre;
  level_t             r_slot;
  logic               r_frame_start;
  logic               w_pre_wrap;

  assign w_pre_wrap  = (r_pre == c_pre_last);
  assign frame_edge  = w_pre_wrap && (r_slot == c_slot_last);
  assign slot        = r_slot;
  assign frame_start = r_frame_start;

  // Prescaler/slot counters; frame_start marks the cycle after the frame edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre         <= '0;
      r_slot        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= frame_edge;
      if (w_pre_wrap) begin
        r_pre <= '0;
        if (r_slot == c_slot_last) begin
          r_slot <= '0;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule : pwm_slot_timer
`default_nettype wire

// File: rtl/led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : led_trail_pwm
//  Brief    : Turns the bouncing-LED pattern into a fading comet trail. Lit
//             bits jump to full brightness, unlit LEDs decay once per step.
//             Steps are held and applied only at frame boundaries so a frame
//             never shows a brightness change part-way through.
//  Revision : 1.0 - initial release
// ============================================================================
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int DECAY   = 2,
  parameter int PWM_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              step,
  output logic [N_LEDS-1:0] leds,
  output logic              frame_start,
  output logic              dropped_step
);

  localparam logic [LEVEL_W:0] c_decay     = (LEVEL_W + 1)'(DECAY);
  localparam level_t           c_level_max = level_t'(LEVEL_MAX);

  level_t   r_level [N_LEDS];
  level_t   w_decayed [N_LEDS];
  led_vec_t r_pat_hold;
  logic     r_pending;
  logic     r_dropped;
  led_vec_t r_leds;

  level_t   w_slot;
  logic     w_frame_edge;
  logic     w_commit;
  led_vec_t w_commit_pat;

  pwm_slot_timer #(
    .PWM_DIV (PWM_DIV)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .slot        (w_slot),
    .frame_edge  (w_frame_edge),
    .frame_start (frame_start)
  );

  // A step arriving on the boundary edge itself is committed directly
  assign w_commit     = w_frame_edge && (r_pending || step);
  assign w_commit_pat = step ? pattern_in : r_pat_hold;

  // Saturating decay: subtract one bit wider and clamp on borrow
  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_decay
      logic [LEVEL_W:0] w_diff;
      assign w_diff        = {1'b0, r_level[gi]} - c_decay;
      assign w_decayed[gi] = w_diff[LEVEL_W] ? '0 : w_diff[LEVEL_W-1:0];
    end
  endgenerate

  // Step capture; a second step before commit overwrites and flags a drop
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pat_hold <= '0;
      r_pending  <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_dropped <= step && r_pending && !w_frame_edge;
      if (step) begin
        r_pat_hold <= pattern_in;
      end
      if (w_commit) begin
        r_pending <= 1'b0;
      end else if (step) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Brightness levels change only on a committed frame boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= w_commit_pat[i] ? c_level_max : w_decayed[i];
      end
    end
  end

  // PWM compare: LED is on while the slot index is below its level
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_leds <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_leds[i] <= (w_slot < r_level[i]);
      end
    end
  end

  assign leds         = r_leds;
  assign dropped_step = r_dropped;

endmodule : led_trail_pwm
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_trail_pwm
//  Brief    : Directed testbench for led_trail_pwm: reset, single step, decay
//             sequence, overwrite/drop, boundary-edge step, mid-frame reset.
//             Per-frame on-cycle counts are compared to hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_trail_pwm;
  import led_pkg::*;

  localparam int c_frame = 28;

  logic     CLK = 1'b0;
  logic     RST;
  led_vec_t pattern_in;
  logic     step;
  led_vec_t leds;
  logic     frame_start;
  logic     dropped_step;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt     [N_LEDS];
  int exp_cnt [N_LEDS];
  int drops;
  int fs_mid;
  int fs_end;
  int n_wait;
  int lit;

  always #5 CLK = ~CLK;

  led_trail_pwm #(
    .DECAY   (2),
    .PWM_DIV (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pattern_in   (pattern_in),
    .step         (step),
    .leds         (leds),
    .frame_start  (frame_start),
    .dropped_step (dropped_step)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Count negedges until frame_start (bounded); note any lit LED meanwhile
  task automatic wait_fs();
    n_wait = 0;
    lit    = 0;
    while (!frame_start && n_wait < 100) begin
      @(negedge CLK);
      n_wait++;
      if (leds != '0) lit = 1;
    end
  endtask

  // Starts at the negedge of a frame_start cycle; samples the 28 cycles that
  // carry this frame's drive and ends on the next frame_start cycle.
  task automatic run_frame(input int s1_at, input led_vec_t s1_pat,
                           input int s2_at, input led_vec_t s2_pat);
    step   = 1'b0;
    drops  = 0;
    fs_mid = 0;
    fs_end = 0;
    for (int i = 0; i < N_LEDS; i++) cnt[i] = 0;
    for (int j = 0; j < c_frame; j++) begin
      @(negedge CLK);
      for (int i = 0; i < N_LEDS; i++) if (leds[i]) cnt[i]++;
      if (dropped_step) drops++;
      if (frame_start) begin
        if (j == c_frame - 1) fs_end = 1;
        else fs_mid++;
      end
      step = 1'b0;
      if (j == s1_at) begin
        step       = 1'b1;
        pattern_in = s1_pat;
      end
      if (j == s2_at) begin
        step       = 1'b1;
        pattern_in = s2_pat;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_drops);
    for (int i = 0; i < N_LEDS; i++) begin
      chk($sformatf("%s led%0d", tag, i), cnt[i], exp_cnt[i]);
    end
    chk({tag, " drops"}, drops, exp_drops);
    chk({tag, " fs_end"}, fs_end, 1);
    chk({tag, " fs_mid"}, fs_mid, 0);
  endtask

  initial begin
    RST        = 1'b1;
    step       = 1'b0;
    pattern_in = 10'h3FF;

    // Reset held two edges with step toggling (high on the last reset edge)
    @(negedge CLK);
    chk("rst leds", leds, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst dropped", dropped_step, 0);
    step = 1'b1;
    @(negedge CLK);
    RST  = 1'b0;
    step = 1'b0;
    wait_fs();
    chk("first frame_start delay", n_wait, c_frame);
    chk("lit before first frame", lit, 0);

    // Frame A: nothing lit yet; single step 001 mid-frame
    exp_cnt = '{default: 0};
    run_frame(10, 10'h001, -1, 10'h000);
    check_frame("A", 0);

    // Frame B: LED0 full; then decay steps
    exp_cnt = '{default: 0};
    exp_cnt[0] = 28;
    run_frame(10, 10'h000, -1, 10'h000);
    check_frame("B", 0);

    exp_cnt[0] = 20;
    run_frame(10, 10'h000, -1, 10'h000);
    check_frame("C", 0);

    exp_cnt[0] = 12;
    run_frame(10, 10'h000, -1, 10'h000);
    check_frame("D", 0);

    exp_cnt[0] = 4;
    run_frame(10, 10'h000, -1, 10'h000);
    check_frame("E", 0);

    // Frame F: decay saturated at 0; relight LED0
    exp_cnt[0] = 0;
    run_frame(5, 10'h001, -1, 10'h000);
    check_frame("F", 0);

    // Frame G: LED0 full; 001 then 200 in the same frame -> one drop
    exp_cnt[0] = 28;
    run_frame(3, 10'h001, 15, 10'h200);
    check_frame("G", 1);

    // Frame H: LED0 7-2=5, LED9 full; pending 001 replaced by 020 on the edge
    exp_cnt[0] = 20;
    exp_cnt[9] = 28;
    run_frame(5, 10'h001, 26, 10'h020);
    check_frame("H", 0);

    // Frame I: boundary step committed: LED5 full, LED0 3, LED9 5
    exp_cnt[0] = 12;
    exp_cnt[5] = 28;
    exp_cnt[9] = 20;
    run_frame(5, 10'h3FF, -1, 10'h000);
    check_frame("I", 0);

    // Frame J: all at level 7; reset at slot 3 with a step in the same cycle
    step = 1'b0;
    repeat (12) @(negedge CLK);
    chk("J all lit", leds, 10'h3FF);
    RST        = 1'b1;
    step       = 1'b1;
    pattern_in = 10'h3FF;
    @(negedge CLK);
    RST  = 1'b0;
    step = 1'b0;
    chk("midrst leds", leds, 0);
    chk("midrst frame_start", frame_start, 0);
    chk("midrst dropped", dropped_step, 0);
    wait_fs();
    chk("midrst frame_start delay", n_wait, c_frame);
    chk("midrst lit before frame", lit, 0);

    exp_cnt = '{default: 0};
    run_frame(-1, 10'h000, -1, 10'h000);
    check_frame("K", 0);

    step = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_trail_pwm
`default_nettype wire
